// File: rtl/nacifra_pkg.sv
// Shared definitions for the nacifra scan display: digit value type and
// active-low seven-segment glyphs ordered {g,f,e,d,c,b,a}.
package nacifra_pkg;

  typedef logic [3:0] digit_val_t;

  localparam logic [6:0] GLYPH_0     = 7'b1000000;
  localparam logic [6:0] GLYPH_1     = 7'b1111001;
  localparam logic [6:0] GLYPH_2     = 7'b0100100;
  localparam logic [6:0] GLYPH_3     = 7'b0110000;
  localparam logic [6:0] GLYPH_4     = 7'b0011001;
  localparam logic [6:0] GLYPH_5     = 7'b0010010;
  localparam logic [6:0] GLYPH_6     = 7'b0000010;
  localparam logic [6:0] GLYPH_7     = 7'b1111000;
  localparam logic [6:0] GLYPH_8     = 7'b0000000;
  localparam logic [6:0] GLYPH_9     = 7'b0010000;
  localparam logic [6:0] GLYPH_A     = 7'b0001000;
  localparam logic [6:0] GLYPH_B     = 7'b0000011;
  localparam logic [6:0] GLYPH_C     = 7'b1000110;
  localparam logic [6:0] GLYPH_D     = 7'b0100001;
  localparam logic [6:0] GLYPH_E     = 7'b0000110;
  localparam logic [6:0] GLYPH_F     = 7'b0001110;
  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
  localparam logic [6:0] GLYPH_ERR   = 7'b0000110;

  function automatic logic [6:0] glyph(input digit_val_t v);
    logic [6:0] g;
    case (v)
      4'h0:    g = GLYPH_0;
      4'h1:    g = GLYPH_1;
      4'h2:    g = GLYPH_2;
      4'h3:    g = GLYPH_3;
      4'h4:    g = GLYPH_4;
      4'h5:    g = GLYPH_5;
      4'h6:    g = GLYPH_6;
      4'h7:    g = GLYPH_7;
      4'h8:    g = GLYPH_8;
      4'h9:    g = GLYPH_9;
      4'hA:    g = GLYPH_A;
      4'hB:    g = GLYPH_B;
      4'hC:    g = GLYPH_C;
      4'hD:    g = GLYPH_D;
      4'hE:    g = GLYPH_E;
      default: g = GLYPH_F;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/nacifra_johnson_dec.sv
// Combinational Johnson-code decoder: JW-bit code to value 0..2*JW-1 plus
// an invalid flag for codes that are not a single run of ones.
module nacifra_johnson_dec
  import nacifra_pkg::*;
#(
  parameter int JW = 5
) (
  input  logic [JW-1:0] code,
  output digit_val_t    value,
  output logic          invalid
);

  logic [3:0] w_ones;
  logic [3:0] w_trans;

  // A legal Johnson state has at most one 0/1 boundary; ones anchored at the
  // MSB count up, ones left at the LSB count down from 2*JW.
  always_comb begin
    w_ones  = '0;
    w_trans = '0;
    for (int i = 0; i < JW; i++) begin
      w_ones = w_ones + 4'(code[i]);
    end
    for (int i = 0; i < JW - 1; i++) begin
      w_trans = w_trans + 4'(code[i] ^ code[i+1]);
    end
    invalid = (w_trans > 4'd1);
    if (code[JW-1] || (w_ones == 4'd0)) begin
      value = w_ones;
    end else begin
      value = digit_val_t'(2 * JW) - w_ones;
    end
  end

endmodule

// File: rtl/nacifra_scan_display.sv
// Multiplexed Johnson-code display scanner with anti-ghost gap and blanking.
// Optional leading-zero blanking is enabled by defining NACIFRA_LZB_EN.
module nacifra_scan_display
  import nacifra_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int JW       = 5,
  parameter int SCAN_DIV = 50000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_DIGITS*JW-1:0] codes,
  input  logic                   load,
  input  logic                   blank,
  output logic [6:0]             seg,
  output logic [N_DIGITS-1:0]    an,
  output logic                   err
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [N_DIGITS*JW-1:0] r_shadow;
  logic [CW-1:0]          r_cnt;
  logic [IW-1:0]          r_idx;
  logic                   r_run;

  logic                w_adv;
  logic [IW-1:0]       w_idx_nxt;
  logic [JW-1:0]       w_code;
  digit_val_t          w_dig_val;
  logic                w_dig_inv;
  logic [6:0]          w_glyph;
  logic [6:0]          w_seg;
  logic                w_err;
  logic [N_DIGITS-1:0] w_an_on;

  function automatic logic f_invalid(input logic [JW-1:0] c);
    int t;
    t = 0;
    for (int i = 0; i < JW - 1; i++) begin
      t = t + int'(c[i] ^ c[i+1]);
    end
    return (t > 1);
  endfunction

  assign w_adv     = r_run && (r_cnt == CW'(SCAN_DIV - 1));
  assign w_idx_nxt = !w_adv ? r_idx :
                     (r_idx == IW'(N_DIGITS - 1)) ? '0 : r_idx + IW'(1);

  // seg follows the upcoming digit so it is settled during the dark gap cycle.
  assign w_code  = r_shadow[int'(w_idx_nxt)*JW +: JW];
  assign w_an_on = ~(N_DIGITS'(1) << r_idx);

  nacifra_johnson_dec #(.JW(JW)) u_dec (
    .code    (w_code),
    .value   (w_dig_val),
    .invalid (w_dig_inv)
  );

  assign w_glyph = w_dig_inv ? GLYPH_ERR : glyph(w_dig_val);

`ifdef NACIFRA_LZB_EN
  logic w_lz_cur;

  // A digit is a leading zero when it and every digit above it hold code zero.
  always_comb begin
    logic w_zrun;
    w_zrun   = 1'b1;
    w_lz_cur = 1'b0;
    for (int i = N_DIGITS - 1; i > 0; i--) begin
      w_zrun = w_zrun && (r_shadow[i*JW +: JW] == '0);
      if (IW'(i) == w_idx_nxt) begin
        w_lz_cur = w_zrun;
      end
    end
  end

  assign w_seg = w_lz_cur ? GLYPH_BLANK : w_glyph;
`else
  assign w_seg = w_glyph;
`endif

  always_comb begin
    w_err = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (f_invalid(r_shadow[i*JW +: JW])) begin
        w_err = 1'b1;
      end
    end
  end

  // r_run stays low for the first edge after reset: that edge acts as the
  // gap cycle of digit 0 and ignores any load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_run    <= 1'b0;
      seg      <= GLYPH_BLANK;
      an       <= '1;
      err      <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (r_run) begin
        if (load) begin
          r_shadow <= codes;
        end
        r_cnt <= w_adv ? '0 : r_cnt + CW'(1);
        r_idx <= w_idx_nxt;
      end
      seg <= w_seg;
      an  <= (!r_run || w_adv || blank) ? '1 : w_an_on;
      err <= w_err;
    end
  end

endmodule
